// File: rtl/axi_ic_pkg.sv
// Shared definitions for the AXI interconnect read path: sequencer states,
// response codes and address-decode constants.
package axi_ic_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_ERR  = 2'd3
    } rd_state_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam int SEL_LSB = 28;
    // Slave count; the read-data router sizes its mux from this too.
    localparam int NUM_SLV = 5;

endpackage

// File: rtl/axi_rd_decerr.sv
// Decode-error read responder: after a load pulse it returns arlen+1 DECERR
// beats with zero data, flagging the last one.
module axi_rd_decerr
    import axi_ic_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        load,
    input  logic [7:0]  load_len,
    input  logic        rready,
    output logic        rvalid,
    output logic        rlast,
    output logic [1:0]  rresp,
    output logic [31:0] rdata,
    output logic        active,
    output logic        done
);

    logic [7:0] cnt_q;
    logic       active_q;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q    <= 8'd0;
            active_q <= 1'b0;
        end else if (load) begin
            cnt_q    <= load_len;
            active_q <= 1'b1;
        end else if (active_q && rready) begin
            if (cnt_q == 8'd0) begin
                active_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q - 8'd1;
            end
        end
    end

    assign rvalid = active_q;
    assign rlast  = active_q && (cnt_q == 8'd0);
    assign rresp  = active_q ? RESP_DECERR : RESP_OKAY;
    assign rdata  = 32'd0;
    assign active = active_q;
    assign done   = active_q && rready && (cnt_q == 8'd0);

endmodule

// File: rtl/axi_rd_ctrl.sv
// Read-side sequencer: accepts one AR at a time, decodes it to a slave window,
// forwards it, and holds the router select until the final R beat.
module axi_rd_ctrl #(
    parameter int SEL_LSB = axi_ic_pkg::SEL_LSB,
    parameter int NUM_SLV = axi_ic_pkg::NUM_SLV
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] m_araddr,
    input  logic [7:0]  m_arlen,
    input  logic [2:0]  m_arsize,
    input  logic [1:0]  m_arburst,
    input  logic        m_arvalid,
    output logic        m_arready,
    output logic [31:0] s_araddr,
    output logic [7:0]  s_arlen,
    output logic [2:0]  s_arsize,
    output logic [1:0]  s_arburst,
    output logic        s_arvalid0,
    output logic        s_arvalid1,
    output logic        s_arvalid2,
    output logic        s_arvalid3,
    output logic        s_arvalid4,
    input  logic        s_arready0,
    input  logic        s_arready1,
    input  logic        s_arready2,
    input  logic        s_arready3,
    input  logic        s_arready4,
    input  logic        m_rvalid,
    input  logic        m_rready,
    input  logic        m_rlast,
    output logic [2:0]  ar_sel_q,
    output logic        de_rvalid,
    output logic        de_rlast,
    output logic [1:0]  de_rresp,
    output logic [31:0] de_rdata,
    input  logic        de_rready,
    output logic        de_active,
    output logic [1:0]  dbg_state
);

    import axi_ic_pkg::*;

    // Every channel transfers on a rising aclk edge where valid and ready are
    // both high; a valid, once raised, keeps its payload until that edge.

    rd_state_e  state_q, state_d;
    logic [3:0] region;
    logic       in_range;
    logic       ar_accept;
    logic [7:0] s_arready_v;
    logic       sel_ready;
    logic       r_last_hs;
    logic       de_load;
    logic       de_done;

    assign region      = m_araddr[SEL_LSB+3 -: 4];
    assign in_range    = ({28'd0, region} < 32'(NUM_SLV));
    assign ar_accept   = m_arvalid && m_arready && (state_q == ST_IDLE);
    assign s_arready_v = {3'b000, s_arready4, s_arready3, s_arready2, s_arready1, s_arready0};
    assign sel_ready   = s_arready_v[ar_sel_q];
    assign r_last_hs   = m_rvalid && m_rready && m_rlast;
    assign de_load     = ar_accept && !in_range;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ar_accept) state_d = in_range ? ST_ADDR : ST_ERR;
            ST_ADDR: if (sel_ready) state_d = ST_DATA;
            ST_DATA: if (r_last_hs) state_d = ST_IDLE;
            ST_ERR:  if (de_done)   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            m_arready <= 1'b0;
            ar_sel_q  <= 3'd0;
            s_araddr  <= 32'd0;
            s_arlen   <= 8'd0;
            s_arsize  <= 3'd0;
            s_arburst <= 2'd0;
        end else begin
            state_q   <= state_d;
            // Moore ready: high exactly while the sequencer sits in IDLE.
            m_arready <= (state_d == ST_IDLE);
            if (ar_accept) begin
                s_araddr  <= m_araddr;
                s_arlen   <= m_arlen;
                s_arsize  <= m_arsize;
                s_arburst <= m_arburst;
                if (in_range) ar_sel_q <= region[2:0];
            end
        end
    end

    assign s_arvalid0 = (state_q == ST_ADDR) && (ar_sel_q == 3'd0);
    assign s_arvalid1 = (state_q == ST_ADDR) && (ar_sel_q == 3'd1);
    assign s_arvalid2 = (state_q == ST_ADDR) && (ar_sel_q == 3'd2);
    assign s_arvalid3 = (state_q == ST_ADDR) && (ar_sel_q == 3'd3);
    assign s_arvalid4 = (state_q == ST_ADDR) && (ar_sel_q == 3'd4);
    assign dbg_state  = state_q;

    axi_rd_decerr u_decerr (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .load     (de_load),
        .load_len (m_arlen),
        .rready   (de_rready),
        .rvalid   (de_rvalid),
        .rlast    (de_rlast),
        .rresp    (de_rresp),
        .rdata    (de_rdata),
        .active   (de_active),
        .done     (de_done)
    );

endmodule

// File: tb/tb_axi_rd_ctrl.sv
// Self-checking bench for axi_rd_ctrl: directed scenarios plus randomized
// transactions checked against a transaction-level reference model.
module tb_axi_rd_ctrl;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic        m_arvalid;
    logic        m_arready;
    logic [31:0] s_araddr;
    logic [7:0]  s_arlen;
    logic [2:0]  s_arsize;
    logic [1:0]  s_arburst;
    logic        s_arvalid0, s_arvalid1, s_arvalid2, s_arvalid3, s_arvalid4;
    logic [4:0]  s_arready_v;
    logic        m_rvalid, m_rready, m_rlast;
    logic [2:0]  ar_sel_q;
    logic        de_rvalid, de_rlast, de_rready, de_active;
    logic [1:0]  de_rresp;
    logic [31:0] de_rdata;
    logic [1:0]  dbg_state;
    logic [4:0]  s_arvalid;

    assign s_arvalid = {s_arvalid4, s_arvalid3, s_arvalid2, s_arvalid1, s_arvalid0};

    axi_rd_ctrl dut (
        .aclk(aclk), .aresetn(aresetn),
        .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize), .s_arburst(s_arburst),
        .s_arvalid0(s_arvalid0), .s_arvalid1(s_arvalid1), .s_arvalid2(s_arvalid2),
        .s_arvalid3(s_arvalid3), .s_arvalid4(s_arvalid4),
        .s_arready0(s_arready_v[0]), .s_arready1(s_arready_v[1]), .s_arready2(s_arready_v[2]),
        .s_arready3(s_arready_v[3]), .s_arready4(s_arready_v[4]),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rlast(m_rlast),
        .ar_sel_q(ar_sel_q),
        .de_rvalid(de_rvalid), .de_rlast(de_rlast), .de_rresp(de_rresp),
        .de_rdata(de_rdata), .de_rready(de_rready), .de_active(de_active),
        .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 aclk = ~aclk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, expected completion)");
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    int         n_checks = 0;
    int         n_errors = 0;
    logic [2:0] exp_q[$];
    logic [2:0] model_sel;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge aclk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_arready"}, m_arready, 0);
        check({tag, "_s_arvalid"}, s_arvalid, 0);
        check({tag, "_s_araddr"}, s_araddr, 0);
        check({tag, "_s_arlen"}, s_arlen, 0);
        check({tag, "_s_arsize_burst"}, {s_arsize, s_arburst}, 0);
        check({tag, "_ar_sel"}, ar_sel_q, 0);
        check({tag, "_de"}, {de_rvalid, de_rlast, de_rresp, de_active}, 0);
        check({tag, "_de_rdata"}, de_rdata, 0);
    endtask

    // ---------------- driver ----------------
    // One full AR transaction from IDLE back to IDLE. A region below 5 is a
    // slave window, anything else must come back as a DECERR burst.
    task automatic run_ar(input logic [31:0] addr, input logic [7:0] len, input int delay,
                          input bit use_pat, input logic [7:0] pat,
                          input bit hold, input logic [31:0] hold_addr);
        logic [3:0] region;
        logic [4:0] onehot;
        logic [2:0] size;
        logic [1:0] burst;
        int         cnt;
        int         beats_left;
        int         beat;
        int         iter;
        bit         rv, rr;
        region = addr[31:28];
        size   = 3'($urandom_range(0, 2));
        burst  = 2'($urandom_range(0, 2));
        check("ar_ready_idle", m_arready, 1);
        m_araddr  = addr;
        m_arlen   = len;
        m_arsize  = size;
        m_arburst = burst;
        m_arvalid = 1'b1;
        tick;
        if (hold) m_araddr = hold_addr;
        else m_arvalid = 1'b0;
        check("ar_ready_busy", m_arready, 0);
        check("s_araddr", s_araddr, addr);
        check("s_arlen", s_arlen, len);
        check("s_arsize_burst", {s_arsize, s_arburst}, {size, burst});
        if (region < 4'd5) begin
            model_sel = region[2:0];
            exp_q.push_back(model_sel);
            onehot = 5'b00001 << region;
            cnt = 0;
            for (int i = 0; i < delay; i++) begin
                if (s_arvalid === onehot) cnt++;
                s_arready_v = 5'($urandom) & ~onehot;
                tick;
            end
            if (s_arvalid === onehot) cnt++;
            s_arready_v = onehot | 5'($urandom);
            tick;
            s_arready_v = 5'd0;
            check("s_arvalid_cycles", cnt, delay + 1);
            check("s_arvalid_drop", s_arvalid, 0);
            check("ar_sel_q", ar_sel_q, exp_q.pop_front());
            beats_left = int'(len) + 1;
            iter = 0;
            while (beats_left > 0) begin
                rv = 1'($urandom_range(0, 1));
                rr = 1'($urandom_range(0, 1));
                if (iter > 50) begin
                    rv = 1'b1;
                    rr = 1'b1;
                end
                m_rvalid = rv;
                m_rready = rr;
                m_rlast  = (beats_left == 1);
                if (rv && rr) beats_left--;
                iter++;
                tick;
                if (beats_left > 0) begin
                    check("ar_ready_data", m_arready, 0);
                    check("s_arvalid_data", s_arvalid, 0);
                    check("s_araddr_stable", s_araddr, addr);
                end
            end
            m_rvalid = 1'b0;
            m_rready = 1'b0;
            m_rlast  = 1'b0;
            check("ar_ready_after_last", m_arready, 1);
            check("s_arvalid_after_last", s_arvalid, 0);
            check("ar_sel_hold", ar_sel_q, model_sel);
        end else begin
            check("de_active", de_active, 1);
            check("s_arvalid_err", s_arvalid, 0);
            check("ar_sel_err", ar_sel_q, model_sel);
            beat = 0;
            iter = 0;
            while (beat <= int'(len)) begin
                rr = use_pat ? pat[iter % 8] : 1'($urandom_range(0, 1));
                if (iter > 50) rr = 1'b1;
                de_rready = rr;
                check("de_rvalid", de_rvalid, 1);
                check("de_rlast", de_rlast, (beat == int'(len)));
                check("de_rresp", de_rresp, 2'b11);
                check("de_rdata", de_rdata, 0);
                check("ar_ready_err", m_arready, 0);
                tick;
                if (rr) beat++;
                iter++;
            end
            de_rready = 1'b0;
            check("de_active_end", de_active, 0);
            check("de_rvalid_end", de_rvalid, 0);
            check("ar_ready_after_err", m_arready, 1);
            check("ar_sel_after_err", ar_sel_q, model_sel);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [3:0]  region;
        logic [31:0] addr;
        aresetn     = 1'b0;
        m_araddr    = 32'd0;
        m_arlen     = 8'd0;
        m_arsize    = 3'd0;
        m_arburst   = 2'd0;
        m_arvalid   = 1'b0;
        s_arready_v = 5'd0;
        m_rvalid    = 1'b0;
        m_rready    = 1'b0;
        m_rlast     = 1'b0;
        de_rready   = 1'b0;
        model_sel   = 3'd0;
        repeat (3) tick;
        check_reset_values("rst");
        aresetn = 1'b1;
        check("arready_before_edge", m_arready, 0);
        tick;
        check("arready_after_release", m_arready, 1);
        check("sel_after_release", ar_sel_q, 0);
        check("s_arvalid_after_release", s_arvalid, 0);

        // Slave 2, len 3, ready after two cycles of valid.
        run_ar(32'h2000_0040, 8'd3, 1, 1'b0, 8'h00, 1'b0, 32'd0);
        // Decode error, len 2, de_rready pattern 1,0,1,1.
        run_ar(32'h7000_0000, 8'd2, 0, 1'b1, 8'b1111_1101, 1'b0, 32'd0);
        // AR held during a slave-4 burst; the held AR goes to slave 0 afterwards.
        run_ar(32'h4000_0100, 8'd5, 0, 1'b0, 8'h00, 1'b1, 32'h0000_1230);
        run_ar(32'h0000_1230, 8'd2, 2, 1'b0, 8'h00, 1'b0, 32'd0);
        // Single-beat burst to slave 3.
        run_ar(32'h3000_0008, 8'd0, 0, 1'b0, 8'h00, 1'b0, 32'd0);

        // Reset while ADDR drives s_arvalid1.
        m_araddr  = 32'h1000_0100;
        m_arlen   = 8'd1;
        m_arvalid = 1'b1;
        tick;
        m_arvalid = 1'b0;
        check("rst_mid_s_arvalid1", s_arvalid, 5'b00010);
        tick;
        aresetn = 1'b0;
        #1;
        check_reset_values("rst_mid");
        model_sel = 3'd0;
        exp_q.delete();
        tick;
        aresetn = 1'b1;
        tick;
        check("rst_mid_arready", m_arready, 1);
        for (int i = 0; i < 3; i++) begin
            check("rst_mid_no_spurious", {s_arvalid, de_rvalid}, 0);
            tick;
        end

        // Randomized transactions.
        for (int t = 0; t < 25; t++) begin
            if ($urandom_range(0, 2) == 0) region = 4'($urandom_range(5, 15));
            else region = 4'($urandom_range(0, 4));
            addr = {region, 28'($urandom)};
            run_ar(addr, 8'($urandom_range(0, 7)), $urandom_range(0, 3), 1'b0, 8'h00, 1'b0, 32'd0);
            repeat ($urandom_range(0, 2)) begin
                check("idle_gap_arready", m_arready, 1);
                tick;
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/axi_rd_ctrl.md
# axi_rd_ctrl

Read-side sequencer for the AXI interconnect. Accepts one master read address (AR) at a time and decodes it to one of five slave windows, then forwards AR to that slave. It holds `ar_sel_q` stable for the read-data router until the final R beat handshakes. Addresses outside all windows are answered internally with a DECERR burst of the requested length.

## Interface
- `SEL_LSB`, default 28: lowest address bit of the 4-bit region field `m_araddr[SEL_LSB+3:SEL_LSB]`.
- `NUM_SLV`, default 5: decoded slaves. Region values 0..NUM_SLV-1 map to slave index; all others are decode errors.

Ports:
- `aclk` in 1: clock; all logic on rising edge.
- `aresetn` in 1: reset, asynchronous and active-low.
- `m_araddr` in 32: master read address.
- `m_arlen` in 8: burst length minus 1.
- `m_arsize` in 3: beat size.
- `m_arburst` in 2: burst type.
- `m_arvalid` in 1: master AR valid.
- `m_arready` out 1: master AR ready.
- `s_araddr` out 32: registered AR address, broadcast to all slaves.
- `s_arlen` out 8: registered AR length, broadcast to all slaves.
- `s_arsize` out 3: registered AR size, broadcast to all slaves.
- `s_arburst` out 2: registered AR burst type, broadcast to all slaves.
- `s_arvalid0..4` out 1 each: per-slave AR valid; at most one high.
- `s_arready0..4` in 1 each: per-slave AR ready.
- `m_rvalid`, `m_rready`, `m_rlast` in 1 each: R handshake as seen at the router master side; monitor only.
- `ar_sel_q` out 3: slave select to the read-data router.
- `de_rvalid` out 1: decode-error responder R valid.
- `de_rlast` out 1: decode-error responder R last.
- `de_rresp` out 2: decode-error responder R response.
- `de_rdata` out 32: decode-error responder R data.
- `de_rready` in 1: decode-error responder R ready.
- `de_active` out 1: high while the error responder owns the R channel; integration selects `de_*` over router output.

## Operation
- States: IDLE, ADDR, DATA, ERR. Reset state is IDLE.
- IDLE: `m_arready`=1. On `m_arvalid && m_arready`, latch address, len, size and burst, and decode the region.
  - Region < NUM_SLV: load `ar_sel_q` = region, go to ADDR.
  - Otherwise: load beat counter = `m_arlen`, go to ERR. `ar_sel_q` is unchanged.
- ADDR: assert `s_arvalid[ar_sel_q]`. The `s_ar*` payload is stable. On `s_arready[ar_sel_q]`, go to DATA. There is no timeout; ADDR waits indefinitely.
- DATA: all `s_arvalid`=0, `m_arready`=0. On `m_rvalid && m_rready && m_rlast`, go to IDLE. Beats without `m_rlast` are ignored.
- ERR: `de_active`=1, `de_rvalid`=1, `de_rresp`=2'b11, `de_rdata`=0, `de_rlast`=(counter==0).
  - On each `de_rvalid && de_rready` with counter≠0: decrement the counter.
  - On that handshake with counter==0: go to IDLE.
- Only one transaction is outstanding; there is no AR queue.
- `ar_sel_q` changes only on an accepted, in-range AR. It holds its value through IDLE so the router stays steady.
- Reset mid-operation: everything returns immediately to reset values. The in-flight transaction is dropped; no R beats are generated.

## Timing
- Reset values: `m_arready`=0, all `s_arvalid`=0, `s_ar*`=0, `ar_sel_q`=0, `de_rvalid`=0, `de_rlast`=0, `de_rresp`=0, `de_rdata`=0, `de_active`=0.
- `m_arready` is a registered Moore output. It rises on the first `aclk` edge after `aresetn` release, and again on the edge that enters IDLE.
- AR accepted at edge T: `m_arready` low and `s_arvalid[sel]` high from T+1. Minimum forward latency is 1 cycle.
- `s_arready` at edge T+k: `s_arvalid` low from T+k+1.
- Final R beat at edge E: `m_arready` high from E+1. Back-to-back AR acceptance is possible at E+1.
- Decode-error AR at edge T: `de_rvalid` high from T+1. Exactly `m_arlen`+1 beats. `de_rlast` is high only on the last beat.
- Simultaneous `m_arvalid` and final R beat: the new AR is not accepted in that cycle, because `m_arready` is 0 in DATA.

## Structure
- Shared package `axi_ic_pkg`:
  - state enum.
  - `RESP_OKAY`=2'b00 and `RESP_DECERR`=2'b11.
  - `SEL_LSB`.
  - slave count constant reused by the read-data router.
- One sub-module is natural: `axi_rd_decerr`. It holds the beat counter and `de_*` generation and is started by a load pulse carrying `arlen`.

## Test plan
- Reset, then release → `m_arready`=1 after one edge; `ar_sel_q`=0; all `s_arvalid`=0.
- AR addr 0x2000_0040, len 3; `s_arready2` after 2 cycles; four R beats, last with rlast → `s_arvalid2` for 2 cycles, `ar_sel_q`=2, `m_arready` low until the cycle after the 4th beat.
- AR addr 0x7000_0000, len 2, `de_rready` toggled 1,0,1,1 → 3 DECERR beats (`de_rresp`=3, `de_rdata`=0); `de_rlast` only on the 3rd; `ar_sel_q` unchanged.
- `m_arvalid` held high during a DATA burst to slave 4 → no second acceptance until after rlast; second AR to slave 0 forwarded the cycle after acceptance.
- `aresetn` low while in ADDR with `s_arvalid1`=1 → all outputs at reset values asynchronously; no spurious `s_arvalid` after release.
- AR len 0 to slave 3 → single-beat rlast returns to IDLE; `m_arready` high the next cycle.
